// File: rtl/stopwatch_counter_bcd.sv
// Packed-BCD stopwatch HH:MM:SS:CC with prescaler, preset load, lap capture and wrap flag.
// Optional countdown mode with expiry pulse is enabled by defining STOPWATCH_COUNTDOWN_EN.
module stopwatch_counter_bcd #(
    parameter int unsigned CLK_DIV  = 1,
    parameter int unsigned HOUR_MAX = 23
) (
    input  logic        clk_100Hz,
    input  logic        rst,
    input  logic        count_en,
    input  logic        mode_down,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        lap,
    output logic [31:0] data_1h,
    output logic [31:0] lap_data,
    output logic        lap_valid,
    output logic        wrap,
    output logic        expired
);

    localparam logic [7:0]  HOUR_MAX_BCD = {4'(HOUR_MAX / 32'd10), 4'(HOUR_MAX % 32'd10)};
    localparam logic [15:0] DIV_LAST     = 16'(CLK_DIV - 32'd1);

    // Out-of-range or non-BCD fields saturate at the field maximum.
    function automatic logic [7:0] clamp_field(input logic [7:0] f, input logic [7:0] max_v);
        if (f[7:4] > 4'd9 || f[3:0] > 4'd9 || f > max_v) begin
            return max_v;
        end else begin
            return f;
        end
    endfunction

    // Returns {carry, next} for a two-digit BCD field counting up to max_v.
    function automatic logic [8:0] bcd_inc(input logic [7:0] f, input logic [7:0] max_v);
        if (f == max_v) begin
            return {1'b1, 8'h00};
        end else if (f[3:0] == 4'd9) begin
            return {1'b0, f[7:4] + 4'd1, 4'd0};
        end else begin
            return {1'b0, f[7:4], f[3:0] + 4'd1};
        end
    endfunction

    logic [31:0] data_1h_r;
    logic [31:0] lap_data_r;
    logic        lap_valid_r;
    logic        wrap_r;
    logic        expired_r;
    logic [15:0] presc_r;

    logic        tick_s;
    logic [8:0]  cc_up_s, ss_up_s, mm_up_s, hh_up_s;
    logic        c_cc_s, c_ss_s, c_mm_s, up_wrap_s;
    logic [31:0] up_next_s;
    logic [31:0] next_s;
    logic        wrap_set_s;
    logic        exp_set_s;
    logic [31:0] load_clean_s;

    assign tick_s = (presc_r == DIV_LAST);

    assign load_clean_s = {clamp_field(load_data[31:24], HOUR_MAX_BCD),
                           clamp_field(load_data[23:16], 8'h59),
                           clamp_field(load_data[15:8],  8'h59),
                           clamp_field(load_data[7:0],   8'h99)};

    assign cc_up_s   = bcd_inc(data_1h_r[7:0],   8'h99);
    assign ss_up_s   = bcd_inc(data_1h_r[15:8],  8'h59);
    assign mm_up_s   = bcd_inc(data_1h_r[23:16], 8'h59);
    assign hh_up_s   = bcd_inc(data_1h_r[31:24], HOUR_MAX_BCD);
    assign c_cc_s    = cc_up_s[8];
    assign c_ss_s    = c_cc_s & ss_up_s[8];
    assign c_mm_s    = c_ss_s & mm_up_s[8];
    assign up_wrap_s = c_mm_s & hh_up_s[8];
    assign up_next_s = {c_mm_s ? hh_up_s[7:0] : data_1h_r[31:24],
                        c_ss_s ? mm_up_s[7:0] : data_1h_r[23:16],
                        c_cc_s ? ss_up_s[7:0] : data_1h_r[15:8],
                        cc_up_s[7:0]};

`ifdef STOPWATCH_COUNTDOWN_EN
    // Returns {borrow, next} for a two-digit BCD field counting down, reloading max_v.
    function automatic logic [8:0] bcd_dec(input logic [7:0] f, input logic [7:0] max_v);
        if (f == 8'h00) begin
            return {1'b1, max_v};
        end else if (f[3:0] == 4'd0) begin
            return {1'b0, f[7:4] - 4'd1, 4'd9};
        end else begin
            return {1'b0, f[7:4], f[3:0] - 4'd1};
        end
    endfunction

    logic [8:0]  cc_dn_s, ss_dn_s, mm_dn_s, hh_dn_s;
    logic        b_cc_s, b_ss_s, b_mm_s;
    logic [31:0] dn_next_s;

    assign cc_dn_s = bcd_dec(data_1h_r[7:0],   8'h99);
    assign ss_dn_s = bcd_dec(data_1h_r[15:8],  8'h59);
    assign mm_dn_s = bcd_dec(data_1h_r[23:16], 8'h59);
    assign hh_dn_s = bcd_dec(data_1h_r[31:24], HOUR_MAX_BCD);
    assign b_cc_s  = cc_dn_s[8];
    assign b_ss_s  = b_cc_s & ss_dn_s[8];
    assign b_mm_s  = b_ss_s & mm_dn_s[8];
    // Zero is sticky in countdown: the borrow chain would otherwise roll to HOUR_MAX.
    assign dn_next_s = (data_1h_r == 32'h0000_0000) ? 32'h0000_0000 :
                       {b_mm_s ? hh_dn_s[7:0] : data_1h_r[31:24],
                        b_ss_s ? mm_dn_s[7:0] : data_1h_r[23:16],
                        b_cc_s ? ss_dn_s[7:0] : data_1h_r[15:8],
                        cc_dn_s[7:0]};

    assign next_s     = mode_down ? dn_next_s : up_next_s;
    assign wrap_set_s = ~mode_down & up_wrap_s;
    assign exp_set_s  = mode_down & (data_1h_r == 32'h0000_0001);
`else
    logic unused_mode_s;

    assign unused_mode_s = mode_down;
    assign next_s        = up_next_s;
    assign wrap_set_s    = up_wrap_s;
    assign exp_set_s     = 1'b0;
`endif

    // Counter, prescaler, lap capture and event pulses.
    always_ff @(posedge clk_100Hz) begin
        if (rst) begin
            data_1h_r   <= 32'h0000_0000;
            lap_data_r  <= 32'h0000_0000;
            lap_valid_r <= 1'b0;
            wrap_r      <= 1'b0;
            expired_r   <= 1'b0;
            presc_r     <= 16'd0;
        end else begin
            wrap_r      <= 1'b0;
            expired_r   <= 1'b0;
            lap_valid_r <= lap;
            if (lap) begin
                lap_data_r <= data_1h_r;
            end
            if (load) begin
                data_1h_r <= load_clean_s;
                presc_r   <= 16'd0;
            end else if (count_en) begin
                if (tick_s) begin
                    presc_r   <= 16'd0;
                    data_1h_r <= next_s;
                    wrap_r    <= wrap_set_s;
                    expired_r <= exp_set_s;
                end else begin
                    presc_r <= presc_r + 16'd1;
                end
            end
        end
    end

    assign data_1h   = data_1h_r;
    assign lap_data  = lap_data_r;
    assign lap_valid = lap_valid_r;
    assign wrap      = wrap_r;
    assign expired   = expired_r;

endmodule

// File: tb/tb_stopwatch_counter_bcd.sv
// Directed bench for stopwatch_counter_bcd: three instances (CLK_DIV=1, CLK_DIV=4,
// HOUR_MAX=99) share one stimulus stream; expectations are hand-computed BCD constants.
module tb_stopwatch_counter_bcd;

    logic        clk = 1'b0;
    logic        rst, count_en, mode_down, load, lap;
    logic [31:0] load_data;

    logic [31:0] d1_data, d1_lap, d4_data, d4_lap, d99_data, d99_lap;
    logic        d1_lv, d1_wrap, d1_exp, d4_lv, d4_wrap, d4_exp, d99_lv, d99_wrap, d99_exp;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    stopwatch_counter_bcd #(.CLK_DIV(1), .HOUR_MAX(23)) dut1 (
        .clk_100Hz(clk), .rst(rst), .count_en(count_en), .mode_down(mode_down),
        .load(load), .load_data(load_data), .lap(lap),
        .data_1h(d1_data), .lap_data(d1_lap), .lap_valid(d1_lv),
        .wrap(d1_wrap), .expired(d1_exp));

    stopwatch_counter_bcd #(.CLK_DIV(4), .HOUR_MAX(23)) dut4 (
        .clk_100Hz(clk), .rst(rst), .count_en(count_en), .mode_down(mode_down),
        .load(load), .load_data(load_data), .lap(lap),
        .data_1h(d4_data), .lap_data(d4_lap), .lap_valid(d4_lv),
        .wrap(d4_wrap), .expired(d4_exp));

    stopwatch_counter_bcd #(.CLK_DIV(1), .HOUR_MAX(99)) dut99 (
        .clk_100Hz(clk), .rst(rst), .count_en(count_en), .mode_down(mode_down),
        .load(load), .load_data(load_data), .lap(lap),
        .data_1h(d99_data), .lap_data(d99_lap), .lap_valid(d99_lv),
        .wrap(d99_wrap), .expired(d99_exp));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Advance n rising edges and settle just past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; count_en = 1'b0; mode_down = 1'b0; load = 1'b0; lap = 1'b0;
        load_data = 32'h0000_0000;
        step(10);
        check_eq("rst_data",  d1_data, 32'h0000_0000);
        check_eq("rst_lap",   d1_lap,  32'h0000_0000);
        check_eq("rst_lv",    {31'd0, d1_lv},   32'd0);
        check_eq("rst_wrap",  {31'd0, d1_wrap}, 32'd0);
        check_eq("rst_exp",   {31'd0, d1_exp},  32'd0);
        check_eq("rst_data4", d4_data, 32'h0000_0000);

        // Basic counting and prescale
        rst = 1'b0; count_en = 1'b1;
        step(400);
        check_eq("cnt400_d1", d1_data, 32'h0000_0400);
        check_eq("cnt400_d4", d4_data, 32'h0000_0100);
        step(5600);
        check_eq("cnt6000_d1",  d1_data,  32'h0001_0000);
        check_eq("cnt6000_d4",  d4_data,  32'h0000_1500);
        check_eq("cnt6000_d99", d99_data, 32'h0001_0000);

        // Enable gating
        rst = 1'b1; step(1); rst = 1'b0;
        count_en = 1'b1; step(3);
        check_eq("gate_pre", d4_data, 32'h0000_0000);
        count_en = 1'b0; step(50);
        count_en = 1'b1; step(3);
        check_eq("gate_d4", d4_data, 32'h0000_0001);
        check_eq("gate_d1", d1_data, 32'h0000_0006);

        // Wrap at HOUR_MAX=23
        count_en = 1'b0; load = 1'b1; load_data = 32'h2359_5999; step(1); load = 1'b0;
        check_eq("wrap_load", d1_data, 32'h2359_5999);
        count_en = 1'b1; step(1);
        check_eq("wrap_data",    d1_data,  32'h0000_0000);
        check_eq("wrap_pulse",   {31'd0, d1_wrap},  32'd1);
        check_eq("wrap99_data",  d99_data, 32'h2400_0000);
        check_eq("wrap99_nowr",  {31'd0, d99_wrap}, 32'd0);
        step(1);
        check_eq("wrap_after",   d1_data,  32'h0000_0001);
        check_eq("wrap_1cyc",    {31'd0, d1_wrap},  32'd0);

        // Wrap at HOUR_MAX=99 (and clamp on the 23-hour instance)
        count_en = 1'b0; load = 1'b1; load_data = 32'h9959_5999; step(1); load = 1'b0;
        check_eq("w99_load",  d99_data, 32'h9959_5999);
        check_eq("w99_clamp", d1_data,  32'h2359_5999);
        count_en = 1'b1; step(1);
        check_eq("w99_data",  d99_data, 32'h0000_0000);
        check_eq("w99_pulse", {31'd0, d99_wrap}, 32'd1);
        check_eq("w23_pulse", {31'd0, d1_wrap},  32'd1);
        step(1);
        check_eq("w99_1cyc",  {31'd0, d99_wrap}, 32'd0);

        // Countdown
        count_en = 1'b0; mode_down = 1'b1; load = 1'b1; load_data = 32'h0000_0002;
        step(1); load = 1'b0;
        count_en = 1'b1; step(1);
`ifdef STOPWATCH_COUNTDOWN_EN
        check_eq("down_1",   d1_data, 32'h0000_0001);
        check_eq("down_1e",  {31'd0, d1_exp}, 32'd0);
        step(1);
        check_eq("down_0",   d1_data, 32'h0000_0000);
        check_eq("down_exp", {31'd0, d1_exp}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_eq("down_hold",  d1_data, 32'h0000_0000);
            check_eq("down_hexp",  {31'd0, d1_exp},  32'd0);
            check_eq("down_hwrap", {31'd0, d1_wrap}, 32'd0);
        end
`else
        check_eq("noctd_3",  d1_data, 32'h0000_0003);
        check_eq("noctd_3e", {31'd0, d1_exp}, 32'd0);
        step(1);
        check_eq("noctd_4",  d1_data, 32'h0000_0004);
        check_eq("noctd_4e", {31'd0, d1_exp}, 32'd0);
`endif
        mode_down = 1'b0; count_en = 1'b0;

        // Load sanitising
        load = 1'b1; load_data = 32'h7A6B_FFFF; step(1); load = 1'b0;
        check_eq("san_d1",  d1_data,  32'h2359_5999);
        check_eq("san_d99", d99_data, 32'h9959_5999);

        // Load wins over a coincident tick
        rst = 1'b1; step(1); rst = 1'b0;
        count_en = 1'b1; step(3);
        load = 1'b1; load_data = 32'h0000_0050; step(1); load = 1'b0;
        check_eq("prio_load", d4_data, 32'h0000_0050);
        step(3);
        check_eq("prio_hold", d4_data, 32'h0000_0050);
        step(1);
        check_eq("prio_tick", d4_data, 32'h0000_0051);

        // Load clears a partial prescaler phase
        rst = 1'b1; step(1); rst = 1'b0;
        count_en = 1'b1; step(1);
        load = 1'b1; load_data = 32'h0000_0070; step(1); load = 1'b0;
        step(3);
        check_eq("pclr_hold", d4_data, 32'h0000_0070);
        step(1);
        check_eq("pclr_tick", d4_data, 32'h0000_0071);

        // Lap coincident with load captures the pre-load value
        rst = 1'b1; step(1); rst = 1'b0;
        count_en = 1'b1; step(42);
        check_eq("lap_pre", d1_data, 32'h0000_0042);
        count_en = 1'b0; lap = 1'b1; load = 1'b1; load_data = 32'h1200_0000;
        step(1); lap = 1'b0; load = 1'b0;
        check_eq("lap_data",  d1_lap,  32'h0000_0042);
        check_eq("lap_valid", {31'd0, d1_lv}, 32'd1);
        check_eq("lap_load",  d1_data, 32'h1200_0000);
        step(1);
        check_eq("lap_1cyc",  {31'd0, d1_lv}, 32'd0);
        check_eq("lap_keep",  d1_lap,  32'h0000_0042);

        // Back-to-back laps each capture the pre-tick value
        count_en = 1'b1; lap = 1'b1; step(1);
        check_eq("lap2_a",   d1_lap,  32'h1200_0000);
        check_eq("lap2_av",  {31'd0, d1_lv}, 32'd1);
        check_eq("lap2_dat", d1_data, 32'h1200_0001);
        step(1); lap = 1'b0;
        check_eq("lap2_b",   d1_lap,  32'h1200_0001);
        check_eq("lap2_bv",  {31'd0, d1_lv}, 32'd1);
        step(1);
        check_eq("lap2_end", {31'd0, d1_lv}, 32'd0);

        // Reset mid-count, with a lap pending
        step(2);
        lap = 1'b1; rst = 1'b1; step(1); rst = 1'b0; lap = 1'b0;
        check_eq("mrst_data", d1_data, 32'h0000_0000);
        check_eq("mrst_lap",  d1_lap,  32'h0000_0000);
        check_eq("mrst_lv",   {31'd0, d1_lv},   32'd0);
        check_eq("mrst_wrap", {31'd0, d1_wrap}, 32'd0);
        check_eq("mrst_exp",  {31'd0, d1_exp},  32'd0);
        step(3);
        check_eq("mrst_presc", d4_data, 32'h0000_0000);
        step(1);
        check_eq("mrst_tick",  d4_data, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
